// File: rtl/isqrt16_iter.sv
// Iterative 16-bit integer square root with valid/ready handshakes on both sides.
// Define ISQRT16_RADIX16_EN to run two cascaded recurrence steps per cycle (latency 4 instead of 8).
module isqrt16_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] rad_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  root_o,
    output logic [8:0]  rem_o
);

`ifdef ISQRT16_RADIX16_EN
    localparam int unsigned BITS_PER_CYCLE = 4;
    localparam logic [2:0]  LAST_COUNT     = 3'd3;
`else
    localparam int unsigned BITS_PER_CYCLE = 2;
    localparam logic [2:0]  LAST_COUNT     = 3'd7;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [15:0] x;
    logic [9:0]  r;
    logic [7:0]  q;
    logic [2:0]  cnt;
    logic [9:0]  r_next;
    logic [7:0]  q_next;

    // One restoring step: bring down the next radicand bit pair, trial-subtract 4q+1.
    function automatic logic [17:0] rec_step(input logic [9:0] r_in,
                                             input logic [7:0] q_in,
                                             input logic [1:0] pair);
        logic [9:0] r_sh;
        logic [9:0] t;
        r_sh = (r_in << 2) | {8'd0, pair};
        t    = {q_in, 2'b01};
        if (r_sh >= t) begin
            return {r_sh - t, (q_in << 1) | 8'd1};
        end
        return {r_sh, q_in << 1};
    endfunction

`ifdef ISQRT16_RADIX16_EN
    logic [17:0] step1;

    always_comb begin
        step1            = rec_step(r, q, x[15:14]);
        {r_next, q_next} = rec_step(step1[17:8], step1[7:0], x[13:12]);
    end
`else
    always_comb begin
        {r_next, q_next} = rec_step(r, q, x[15:14]);
    end
`endif

    assign in_ready = (state == IDLE);

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            r         <= '0;
            q         <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            root_o    <= '0;
            rem_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x     <= rad_i;
                        r     <= '0;
                        q     <= '0;
                        cnt   <= LAST_COUNT;
                        state <= CALC;
                    end
                end
                CALC: begin
                    x   <= x << BITS_PER_CYCLE;
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd0) begin
                        root_o    <= q_next;
                        rem_o     <= r_next[8:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
